// File: rtl/lcd_text_sequencer.sv
// Command/text source for the character-LCD write controller: holds a 2x16 text
// buffer and replays init (first pass only) plus both lines as single-byte transfers.
module lcd_text_sequencer #(
    parameter int CMD_DELAY   = 2000,
    parameter int CLEAR_DELAY = 100000
) (
    input  logic       iCLK,
    input  logic       rst,
    input  logic       iWr,
    input  logic [4:0] iAddr,
    input  logic [7:0] iChar,
    input  logic       iRefresh,
    output logic       oBusy,
    output logic       oInitDone,
    output logic [7:0] oLCD_DATA,
    output logic       oLCD_RS,
    output logic       oLCD_Start,
    input  logic       iLCD_Done
);

    localparam int MAX_DELAY = (CMD_DELAY > CLEAR_DELAY) ? CMD_DELAY : CLEAR_DELAY;
    localparam int CW        = $clog2(MAX_DELAY) + 1;

    localparam logic [5:0] IDX_INIT_LAST = 6'd4;
    localparam logic [5:0] IDX_LINE1_END = 6'd20;
    localparam logic [5:0] IDX_LINE2_CMD = 6'd21;
    localparam logic [5:0] IDX_LAST      = 6'd37;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_ARM,
        S_WAIT,
        S_DELAY,
        S_NEXT
    } state_t;

    state_t        state_q, state_d;
    logic [5:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic          busy_q, busy_d;
    logic          init_q, init_d;
    logic [7:0]    data_q, data_d;
    logic          rs_q, rs_d;

    logic [7:0]    buf_q [32];
    logic [7:0]    sel_byte;
    logic          sel_rs;
    logic [5:0]    off1, off2;

    always_ff @(posedge iCLK) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) buf_q[i] <= 8'h20;
        end else if (iWr) begin
            buf_q[iAddr] <= iChar;
        end
    end

    // Byte/RS for the current transfer index; line 2 lives in buffer[16..31].
    always_comb begin
        off1     = idx_q - 6'd5;
        off2     = idx_q - 6'd22;
        sel_rs   = 1'b1;
        sel_byte = 8'h20;
        if (idx_q <= IDX_INIT_LAST) begin
            sel_rs = 1'b0;
            case (idx_q[2:0])
                3'd0:    sel_byte = 8'h38;
                3'd1:    sel_byte = 8'h0C;
                3'd2:    sel_byte = 8'h01;
                3'd3:    sel_byte = 8'h06;
                default: sel_byte = 8'h80;
            endcase
        end else if (idx_q <= IDX_LINE1_END) begin
            sel_byte = buf_q[{1'b0, off1[3:0]}];
        end else if (idx_q == IDX_LINE2_CMD) begin
            sel_rs   = 1'b0;
            sel_byte = 8'hC0;
        end else begin
            sel_byte = buf_q[{1'b1, off2[3:0]}];
        end
    end

    always_ff @(posedge iCLK) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b0;
            init_q  <= 1'b0;
            data_q  <= '0;
            rs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            busy_q  <= busy_d;
            init_q  <= init_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        busy_d  = busy_q;
        init_d  = init_q;
        data_d  = data_q;
        rs_d    = rs_q;

        if (iRefresh && busy_q) pend_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (iRefresh || pend_q) begin
                    state_d = S_LOAD;
                    idx_d   = init_q ? IDX_INIT_LAST : 6'd0;
                    pend_d  = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            S_LOAD: begin
                data_d  = sel_byte;
                rs_d    = sel_rs;
                state_d = S_SEND;
            end
            S_SEND: state_d = S_ARM;
            // The controller's done from the previous transfer is stale until it drops.
            S_ARM: begin
                if (!iLCD_Done) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (iLCD_Done) begin
                    cnt_d   = (data_q == 8'h01 && !rs_q) ? CW'(CLEAR_DELAY) : CW'(CMD_DELAY);
                    state_d = S_DELAY;
                end
            end
            S_DELAY: begin
                if (cnt_q <= CW'(1)) begin
                    cnt_d   = '0;
                    state_d = S_NEXT;
                end else begin
                    cnt_d   = cnt_q - CW'(1);
                end
            end
            S_NEXT: begin
                if (idx_q == IDX_INIT_LAST) init_d = 1'b1;
                if (idx_q == IDX_LAST) begin
                    state_d = S_IDLE;
                    // Keep busy asserted when a queued pass will start from IDLE.
                    busy_d  = pend_d;
                end else begin
                    idx_d   = idx_q + 6'd1;
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign oBusy      = busy_q;
    assign oInitDone  = init_q;
    assign oLCD_DATA  = data_q;
    assign oLCD_RS    = rs_q;
    assign oLCD_Start = (state_q == S_SEND);

endmodule
